// File: rtl/wbsdram_arb_pkg.sv
// Shared encodings for the two-master SDRAM Wishbone arbiter.
package wbsdram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_A = 2'd1,
        ST_GRANT_B = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_A    = 2'b01;
    localparam logic [1:0] GNT_B    = 2'b10;

endpackage

// File: rtl/wbsdram_inflight.sv
// Up/down count of requests accepted by the slave but not yet acknowledged.
module wbsdram_inflight #(
    parameter int LGFLIGHT = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);

    logic [LGFLIGHT-1:0] count;

    always_ff @(posedge clk) begin
        // NOTE: sequential state is written only with non-blocking assignments.
        if (!reset_n || clear)
            count <= '0;
        else if (inc && !dec)
            count <= count + LGFLIGHT'(1);
        else if (dec && !inc)
            count <= count - LGFLIGHT'(1);
    end

    assign full  = &count;
    assign empty = (count == '0);

endmodule

// File: rtl/wbsdram_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone SDRAM slave between a CPU (A) and a DMA (B),
// with a per-grant beat limit so a streaming master yields to a waiting one.
module wbsdram_arbiter
    import wbsdram_arb_pkg::*;
#(
    parameter int AW       = 26,
    parameter int DW       = 32,
    parameter int LGFLIGHT = 5,
    parameter int MAXBURST = 64
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_a_cyc,
    input  logic            i_a_stb,
    input  logic            i_a_we,
    input  logic [AW-1:0]   i_a_addr,
    input  logic [DW-1:0]   i_a_data,
    input  logic [DW/8-1:0] i_a_sel,
    output logic            o_a_stall,
    output logic            o_a_ack,
    output logic            o_a_err,
    output logic [DW-1:0]   o_a_data,
    input  logic            i_b_cyc,
    input  logic            i_b_stb,
    input  logic            i_b_we,
    input  logic [AW-1:0]   i_b_addr,
    input  logic [DW-1:0]   i_b_data,
    input  logic [DW/8-1:0] i_b_sel,
    output logic            o_b_stall,
    output logic            o_b_ack,
    output logic            o_b_err,
    output logic [DW-1:0]   o_b_data,
    output logic            o_s_cyc,
    output logic            o_s_stb,
    output logic            o_s_we,
    output logic [AW-1:0]   o_s_addr,
    output logic [DW-1:0]   o_s_data,
    output logic [DW/8-1:0] o_s_sel,
    input  logic            i_s_stall,
    input  logic            i_s_ack,
    input  logic            i_s_err,
    input  logic [DW-1:0]   i_s_data,
    output logic [1:0]      o_grant
);

    localparam logic [7:0] BEAT_MAX = 8'(MAXBURST);

    state_t     state;
    logic [1:0] grant;
    logic [1:0] last;
    logic [7:0] beat;

    logic cur_cyc, cur_stb, other_cyc;
    logic streaming, yield, open, accept, ack_ok;
    logic full, empty;
    logic own_a, own_b, pick_a;

    assign own_a = (grant == GNT_A);
    assign own_b = (grant == GNT_B);

    always_comb begin
        // NOTE: every signal gets a default before the branches so no latch is inferred.
        cur_cyc   = 1'b0;
        cur_stb   = 1'b0;
        other_cyc = 1'b0;
        o_s_we    = 1'b0;
        o_s_addr  = '0;
        o_s_data  = '0;
        o_s_sel   = '0;
        if (own_a) begin
            cur_cyc   = i_a_cyc;
            cur_stb   = i_a_stb;
            other_cyc = i_b_cyc;
            o_s_we    = i_a_we;
            o_s_addr  = i_a_addr;
            o_s_data  = i_a_data;
            o_s_sel   = i_a_sel;
        end else if (own_b) begin
            cur_cyc   = i_b_cyc;
            cur_stb   = i_b_stb;
            other_cyc = i_a_cyc;
            o_s_we    = i_b_we;
            o_s_addr  = i_b_addr;
            o_s_data  = i_b_data;
            o_s_sel   = i_b_sel;
        end
    end

    // Once the beat limit is hit and the other master waits, stop issuing in the same cycle
    // so exactly MAXBURST requests are accepted before draining.
    assign streaming = (state == ST_GRANT_A) || (state == ST_GRANT_B);
    assign yield     = streaming && (beat == BEAT_MAX) && other_cyc;
    assign open      = streaming && !full && !yield;

    assign o_s_cyc = cur_cyc;
    assign o_s_stb = cur_cyc && cur_stb && open;
    assign accept  = o_s_stb && !i_s_stall;
    assign ack_ok  = i_s_ack && !empty;

    assign o_a_stall = !(own_a && open) || i_s_stall;
    assign o_b_stall = !(own_b && open) || i_s_stall;
    assign o_a_ack   = own_a && ack_ok;
    assign o_b_ack   = own_b && ack_ok;
    assign o_a_err   = own_a && i_s_err;
    assign o_b_err   = own_b && i_s_err;
    assign o_a_data  = i_s_data;
    assign o_b_data  = i_s_data;
    assign o_grant   = grant;

    wbsdram_inflight #(.LGFLIGHT(LGFLIGHT)) u_inflight (
        .clk     (i_clk),
        .reset_n (i_reset_n),
        .clear   (!cur_cyc || i_s_err),
        .inc     (accept),
        .dec     (ack_ok),
        .full    (full),
        .empty   (empty)
    );

    // On a tie the master that was not granted last wins.
    assign pick_a = i_a_cyc && (!i_b_cyc || (last == GNT_B));

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
            grant <= GNT_NONE;
            last  <= GNT_B;
            beat  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_a) begin
                        state <= ST_GRANT_A;
                        grant <= GNT_A;
                        last  <= GNT_A;
                        beat  <= '0;
                    end else if (i_b_cyc) begin
                        state <= ST_GRANT_B;
                        grant <= GNT_B;
                        last  <= GNT_B;
                        beat  <= '0;
                    end
                end
                ST_GRANT_A, ST_GRANT_B: begin
                    if (!cur_cyc || i_s_err) begin
                        state <= ST_IDLE;
                        grant <= GNT_NONE;
                    end else if (yield) begin
                        state <= ST_DRAIN;
                    end else if (accept && beat != BEAT_MAX) begin
                        beat <= beat + 8'd1;
                    end
                end
                ST_DRAIN: begin
                    if (!cur_cyc || i_s_err || empty) begin
                        state <= ST_IDLE;
                        grant <= GNT_NONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= GNT_NONE;
                end
            endcase
        end
    end

endmodule
